// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared types and constants for the instruction fetch controller.
package pc_fetch_ctrl_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_INC = 4;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD} fetch_state_e;
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/pc_fetch_ctrl_buffer.sv
// fetch_buffer: two-entry shifting FIFO feeding the IF/ID slot; head is always entry 0.
module fetch_buffer
    import pc_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    fetch_entry_t e0, e1;
    logic [1:0] wr_idx;
    always_comb begin
        head = e0;
        wr_idx = count - 2'(pop);
    end
    // A write to e0 after a pop overrides the shift of e1 into e0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            if (pop) e0 <= e1;
            if (push && wr_idx == 2'd0) e0 <= din;
            if (push && wr_idx != 2'd0) e1 <= din;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencing, single-outstanding imem requests and redirect/flush handling.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int PC_W = 9,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    input  logic               stall_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               ifid_valid_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               flush_o
);
    fetch_state_e state;
    logic [PC_W-1:0] pc_q, tag_q;
    logic [1:0] count;
    fetch_entry_t head, din;
    logic valid, push, pop, req;
    always_comb begin
        valid = count != 2'd0;
        pop = valid && !stall_i && !redirect_i;
        push = state == S_WAIT && imem_rvalid_i && !redirect_i;
        // A retiring response frees the request slot in the same cycle, so count it as buffered.
        req = !redirect_i && (state == S_FETCH || push)
            && (int'(count) + int'(push) - int'(pop) < BUF_DEPTH);
        din = '{pc: 32'(tag_q), instr: imem_rdata_i};
        imem_req_o = req && !reset;
        imem_addr_o = pc_q;
        flush_o = redirect_i && !reset;
        ifid_valid_o = valid && !reset;
        ifid_pc_o = reset ? '0 : head.pc[PC_W-1:0];
        ifid_instr_o = reset ? '0 : valid ? head.instr : NOP;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc_q <= '0;
            tag_q <= '0;
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[PC_W-1:2], 2'b00};
            state <= (state != S_FETCH && !imem_rvalid_i) ? S_DISCARD : S_FETCH;
        end else begin
            if (req && imem_gnt_i) begin
                pc_q <= pc_q + PC_W'(PC_INC);
                tag_q <= pc_q;
            end
            state <= (req && imem_gnt_i) ? S_WAIT
                   : (state != S_FETCH && imem_rvalid_i) ? S_FETCH : state;
        end
    end
    fetch_buffer u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect_i),
        .din   (din),
        .count (count),
        .head  (head)
    );
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: vector table plus redirect/reset sequences, with an instruction scoreboard.
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [8:0]  imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        ifid_valid_o;
    logic [8:0]  ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        flush_o;

    pc_fetch_ctrl #(.PC_W(9), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o),
        .flush_o       (flush_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, rd;
        logic [31:0] rpc;
        logic st, g, h, e_req;
        logic [8:0] e_addr;
        logic e_valid, e_flush;
    } vec_t;

    int checks = 0;
    int errors = 0;
    string tag = "";
    logic [8:0] exp_q[$];
    logic pend = 1'b0;
    logic [8:0] pend_addr = '0;

    function automatic logic [31:0] word(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'b0, a};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, n, act, exp);
        end
    endtask

    // Memory responds one cycle after a grant unless h holds the response back a cycle.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic st,
                        input logic g, input logic h, input logic e_req, input logic [8:0] e_addr,
                        input logic e_valid, input logic e_flush);
        @(negedge clk);
        reset = r;
        redirect_i = rd;
        redirect_pc_i = rpc;
        stall_i = st;
        imem_gnt_i = g;
        imem_rvalid_i = pend && !h;
        imem_rdata_i = word(pend_addr);
        #1;
        chk("req", 32'(imem_req_o), 32'(e_req));
        if (e_req) chk("addr", 32'(imem_addr_o), 32'(e_addr));
        chk("valid", 32'(ifid_valid_o), 32'(e_valid));
        chk("flush", 32'(flush_o), 32'(e_flush));
        if (r) begin
            chk("rst_pc", 32'(ifid_pc_o), 32'd0);
            chk("rst_instr", ifid_instr_o, 32'd0);
        end
        if (!r && !rd && ifid_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s ifid_unexpected: got pc %h expected no instruction", tag, ifid_pc_o);
            end else begin
                chk("ifid_pc", 32'(ifid_pc_o), 32'(exp_q[0]));
                chk("ifid_instr", ifid_instr_o, word(exp_q[0]));
                if (!st) void'(exp_q.pop_front());
            end
        end
        if (r || rd) exp_q.delete();
        if (!r && e_req && g) exp_q.push_back(e_addr);
        if (imem_rvalid_i) pend = 1'b0;
        if (imem_req_o && imem_gnt_i) begin
            pend = 1'b1;
            pend_addr = imem_addr_o;
        end
    endtask

    task automatic do_reset();
        step('1, '0, 32'h0, '0, '1, '1, '0, 9'h0, '0, '0);
    endtask

    vec_t tbl[12];

    initial begin
        tbl = '{
            '{'1, '1, 32'h40, '1, '1, '0, '0, 9'h000, '0, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h000, '0, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h004, '0, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h008, '1, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h00C, '1, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h010, '1, '0},
            '{'0, '0, 32'h0,  '1, '1, '0, '0, 9'h000, '1, '0},
            '{'0, '0, 32'h0,  '1, '1, '0, '0, 9'h000, '1, '0},
            '{'0, '0, 32'h0,  '1, '1, '0, '0, 9'h000, '1, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h014, '1, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h018, '1, '0},
            '{'0, '0, 32'h0,  '0, '1, '0, '1, 9'h01C, '1, '0}
        };
        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("tbl%0d", i);
            step(tbl[i].r, tbl[i].rd, tbl[i].rpc, tbl[i].st, tbl[i].g, tbl[i].h,
                 tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_flush);
        end

        tag = "redir_wait";
        do_reset();
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h000, '0, '0);
        step('0, '1, 32'h40, '0, '1, '1, '0, 9'h000, '0, '1);
        step('0, '0, 32'h0,  '0, '1, '0, '0, 9'h000, '0, '0);
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h040, '0, '0);
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h044, '0, '0);
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h048, '1, '0);
        step('0, '0, 32'h0,  '0, '0, '0, '1, 9'h04C, '1, '0);
        step('0, '0, 32'h0,  '0, '0, '0, '1, 9'h04C, '1, '0);

        tag = "redir_stall";
        do_reset();
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h000, '0, '0);
        step('0, '0, 32'h0,  '1, '1, '0, '1, 9'h004, '0, '0);
        step('0, '1, 32'h80, '1, '1, '0, '0, 9'h000, '1, '1);
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h080, '0, '0);
        step('0, '0, 32'h0,  '0, '0, '0, '1, 9'h084, '0, '0);
        step('0, '0, 32'h0,  '0, '0, '0, '1, 9'h084, '1, '0);

        tag = "wrap_align";
        do_reset();
        step('0, '1, 32'h21FC, '0, '1, '0, '0, 9'h000, '0, '1);
        step('0, '0, 32'h0,    '0, '1, '0, '1, 9'h1FC, '0, '0);
        step('0, '0, 32'h0,    '0, '1, '0, '1, 9'h000, '0, '0);
        step('0, '1, 32'h107,  '0, '1, '0, '0, 9'h000, '1, '1);
        step('0, '0, 32'h0,    '0, '1, '0, '1, 9'h104, '0, '0);
        step('0, '0, 32'h0,    '0, '0, '0, '1, 9'h108, '0, '0);
        step('0, '0, 32'h0,    '0, '0, '0, '1, 9'h108, '1, '0);

        tag = "reset_mid";
        do_reset();
        step('0, '0, 32'h0, '0, '1, '0, '1, 9'h000, '0, '0);
        step('1, '0, 32'h0, '0, '1, '1, '0, 9'h000, '0, '0);
        step('0, '0, 32'h0, '0, '1, '0, '1, 9'h000, '0, '0);
        step('0, '0, 32'h0, '0, '0, '0, '1, 9'h004, '0, '0);
        step('0, '0, 32'h0, '0, '0, '0, '1, 9'h004, '1, '0);

        tag = "double_redir";
        do_reset();
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h000, '0, '0);
        step('0, '1, 32'h40, '0, '1, '1, '0, 9'h000, '0, '1);
        step('0, '1, 32'h60, '0, '1, '1, '0, 9'h000, '0, '1);
        step('0, '0, 32'h0,  '0, '1, '0, '0, 9'h000, '0, '0);
        step('0, '0, 32'h0,  '0, '1, '0, '1, 9'h060, '0, '0);
        step('0, '0, 32'h0,  '0, '0, '0, '1, 9'h064, '0, '0);
        step('0, '0, 32'h0,  '0, '0, '0, '1, 9'h064, '1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
